// File: rtl/fmul_pipe.sv
// Two-stage pipelined IEEE-754 single-precision multiplier (y = x1 * x2).
// Stage 1 forms sign, biased exponent sum, raw 48-bit product and special
// flags; stage 2 normalises, rounds to nearest even and selects the result.
module fmul_pipe #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        in_valid,
  input  logic        stall,
  output logic [31:0] y,
  output logic        out_valid
);

  if (LAT != 2) begin : g_lat_check
    $error("fmul_pipe supports LAT == 2 only");
  end

  // ---------------- stage 1: operand decode and raw product ----------------
  logic [7:0]        ea, eb;
  logic              s_d;
  logic signed [9:0] e_d;
  logic [47:0]       ma, mb, p_d;
  logic              zero_d, inf_d;

  assign ea     = x1[30:23];
  assign eb     = x2[30:23];
  assign s_d    = x1[31] ^ x2[31];
  assign e_d    = $signed({2'b00, ea} + {2'b00, eb} - 10'd127);
  assign ma     = {24'd0, 1'b1, x1[22:0]};
  assign mb     = {24'd0, 1'b1, x2[22:0]};
  assign p_d    = ma * mb;
  // Denormal inputs are flushed; NaN inputs fold into the inf path.
  assign zero_d = (ea == 8'h00) || (eb == 8'h00);
  assign inf_d  = (ea == 8'hff) || (eb == 8'hff);

  logic              v1, s1, zero1, inf1;
  logic signed [9:0] e1;
  logic [47:0]       p1;

  // ---------------- stage 2: normalise, round, select ----------------------
  logic [22:0]       mant;
  logic              guard, sticky;
  logic signed [9:0] e_n;
  logic [23:0]       mant_r;
  logic [31:0]       y_d;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    mant   = p1[45:23];
    guard  = p1[22];
    sticky = |p1[21:0];
    e_n    = e1;
    if (p1[47]) begin
      mant   = p1[46:24];
      guard  = p1[23];
      sticky = |p1[22:0];
      e_n    = e1 + 10'sd1;
    end
    mant_r = {1'b0, mant} + {23'd0, guard & (sticky | mant[0])};
    // A carry out of the mantissa leaves mant_r[22:0] all zero: bump exponent.
    if (mant_r[23]) begin
      e_n = e_n + 10'sd1;
    end

    if (inf1 && zero1) begin
      y_d = 32'h7fc00000;
    end else if (inf1) begin
      y_d = {s1, 8'hff, 23'd0};
    end else if (zero1) begin
      y_d = {s1, 31'd0};
    end else if (e_n >= 10'sd255) begin
      y_d = {s1, 8'hff, 23'd0};
    end else if (e_n <= 10'sd0) begin
      y_d = {s1, 31'd0};
    end else begin
      y_d = {s1, e_n[7:0], mant_r[22:0]};
    end
  end

  // NOTE: pipeline state uses non-blocking assignments so every stage samples
  // the previous value of its upstream register on the same edge. The whole
  // datapath is cleared by reset because y must read zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      s1        <= 1'b0;
      e1        <= '0;
      p1        <= '0;
      zero1     <= 1'b0;
      inf1      <= 1'b0;
      y         <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      v1        <= in_valid;
      s1        <= s_d;
      e1        <= e_d;
      p1        <= p_d;
      zero1     <= zero_d;
      inf1      <= inf_d;
      y         <= y_d;
      out_valid <= v1;
    end
  end

endmodule

// File: tb/tb_fmul_pipe.sv
// Directed bench for fmul_pipe: table of hand-computed products plus
// sequences for streaming with stall and asynchronous reset mid-flight.
module tb_fmul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x1, x2;
  logic        in_valid, stall;
  logic [31:0] y;
  logic        out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  fmul_pipe #(.LAT(2)) dut (
    .clk(clk), .rst(rst), .x1(x1), .x2(x2), .in_valid(in_valid),
    .stall(stall), .y(y), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one operand pair; the product is registered by the second edge.
  task automatic run_vec(input vec_t v, input bit check_tail);
    @(negedge clk);
    x1 = v.a; x2 = v.b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({v.name, " mid valid"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check({v.name, " valid"}, {31'd0, out_valid}, 32'd1);
    check({v.name, " y"}, y, v.exp);
    if (check_tail) begin
      @(negedge clk);
      check({v.name, " single-cycle valid"}, {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{"basic",        32'h3fc00000, 32'h40000000, 32'h40400000};
    vecs[1]  = '{"sign_mant",    32'h437f0000, 32'hc37f0000, 32'hc77e0100};
    vecs[2]  = '{"sticky_down",  32'h3f800001, 32'h3f800001, 32'h3f800002};
    vecs[3]  = '{"neg_zero",     32'h00000000, 32'hbf800000, 32'h80000000};
    vecs[4]  = '{"overflow",     32'h7f0ccccd, 32'h7e99999a, 32'h7f800000};
    vecs[5]  = '{"underflow",    32'h00800000, 32'h00800000, 32'h00000000};
    vecs[6]  = '{"inf_x_zero",   32'h7f800000, 32'h00000000, 32'h7fc00000};
    vecs[7]  = '{"round_up",     32'h3fc00001, 32'h3fc00001, 32'h40100002};
    vecs[8]  = '{"round_carry",  32'h3ffffffe, 32'h3f800001, 32'h40000000};
    vecs[9]  = '{"max_exp",      32'h7f000000, 32'h3f800000, 32'h7f000000};
    vecs[10] = '{"e_zero_flush", 32'h00800000, 32'h3f000000, 32'h00000000};
    vecs[11] = '{"neg_inf",      32'h7f800000, 32'hbf800000, 32'hff800000};
    vecs[12] = '{"nan_as_inf",   32'h7fc00001, 32'h3f800000, 32'h7f800000};
    vecs[13] = '{"denorm_flush", 32'h00000001, 32'h3f800000, 32'h00000000};

    rst = 1'b1; x1 = '0; x2 = '0; in_valid = 1'b0; stall = 1'b0;
    #3;
    check("reset y", y, 32'h0);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i == 0);

    // Streaming: A, B, then C held under a 3-cycle stall, then D.
    @(negedge clk);
    x1 = vecs[0].a; x2 = vecs[0].b; in_valid = 1'b1;
    @(negedge clk);
    x1 = 32'h40400000; x2 = 32'h40400000;
    @(negedge clk);
    check("stream A valid", {31'd0, out_valid}, 32'd1);
    check("stream A y", y, 32'h40400000);
    x1 = vecs[1].a; x2 = vecs[1].b; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall hold valid", {31'd0, out_valid}, 32'd1);
      check("stall hold y", y, 32'h40400000);
    end
    stall = 1'b0;
    @(negedge clk);
    check("stream B valid", {31'd0, out_valid}, 32'd1);
    check("stream B y", y, 32'h41100000);
    x1 = vecs[8].a; x2 = vecs[8].b;
    @(negedge clk);
    check("stream C valid", {31'd0, out_valid}, 32'd1);
    check("stream C y", y, 32'hc77e0100);
    in_valid = 1'b0;
    @(negedge clk);
    check("stream D valid", {31'd0, out_valid}, 32'd1);
    check("stream D y", y, 32'h40000000);
    @(negedge clk);
    check("stream drained", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset with two operations in flight.
    @(negedge clk);
    x1 = vecs[0].a; x2 = vecs[0].b; in_valid = 1'b1;
    @(negedge clk);
    x1 = vecs[1].a; x2 = vecs[1].b;
    @(posedge clk);
    #2;
    check("pre-reset valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("async reset y", y, 32'h0);
    check("async reset valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no stale after reset", {31'd0, out_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fmul_pipe.md
Name: fmul_pipe

Overview:
- Two-stage pipelined IEEE-754 single-precision multiplier: y = x1 * x2.
- Complementary datapath to the FPU divider, sharing its x1/x2/y operand convention.
- Adds valid tracking and a stall so the FPU issue logic can stream operands back-to-back.
- Used by the core for FMUL and as the final multiply stage of reciprocal-based division.

Parameters:
- LAT, 2, pipeline depth in cycles. Fixed at 2; any other value is unsupported and is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- x1  input  32  multiplicand (IEEE single)
- x2  input  32  multiplier (IEEE single)
- in_valid  input  1  x1/x2 valid this cycle
- stall  input  1  freeze the whole pipeline
- y  output  32  product (IEEE single)
- out_valid  output  1  y valid

Behaviour:
- Reset (async, rst=1):
  - all pipeline registers clear; y=32'h00000000, out_valid=0 immediately.
  - Reset mid-operation discards all in-flight operands.
- Advance and latency:
  - Pipeline advances on every rising edge with stall=0 and rst=0.
  - Operands sampled at edge N (in_valid=1, stall=0) appear on y with out_valid=1 after edge N+2.
  - Throughput is 1 operation per cycle.
- Stall:
  - stall=1 holds every stage register including y/out_valid.
  - Inputs are ignored on a stalled cycle.
  - The issuer must hold x1/x2/in_valid until stall is released.
- Bubbles:
  - in_valid=0 injects a bubble: out_valid=0 two cycles later.
  - y contents are don't-care when out_valid=0, except after reset (zero).
- Stage 1 (register on edge):
  - sign s = x1[31]^x2[31].
  - Exponent e = x1[30:23] + x2[30:23] - 127, 10-bit signed.
  - 48-bit product p = {1,x1[22:0]} * {1,x2[22:0]}.
  - Register special flags: zero (either exponent == 0; denormals flushed to zero) and inf (either exponent == 255).
- Stage 2 (normalise/round, register on edge):
  - If p[47]=1: mant=p[46:24], guard=p[23], sticky=|p[22:0], e=e+1.
  - Otherwise: mant=p[45:23], guard=p[22], sticky=|p[21:0].
  - Round to nearest even: increment when guard & (sticky | mant[0]).
  - If the increment carries out of 23 bits: mant=0, e=e+1.
- Result select, in priority order:
  1. inf & zero -> 32'h7fc00000 (canonical NaN).
  2. inf -> {s,8'hff,23'h0}. NaN inputs are treated as inf; no NaN propagation.
  3. zero -> {s,31'h0}.
  4. e >= 255 after rounding -> {s,8'hff,23'h0} (overflow to inf).
  5. e <= 0 -> {s,31'h0} (underflow flushed, no denormal output).
  6. Otherwise -> {s,e[7:0],mant}.
- Simultaneous events:
  - rst overrides stall and in_valid.
  - stall overrides in_valid.

Test Plan:
- Basic product: x1=3fc00000, x2=40000000, in_valid pulse -> two edges later y=40400000, out_valid=1 for exactly one cycle.
- Sign and large mantissa: x1=437f0000, x2=c37f0000 -> y=c77e0100.
- Rounding and zero sign: x1=x2=3f800001 -> y=3f800002 (sticky rounds down). Then x1=00000000, x2=bf800000 -> y=80000000.
- Specials and range limits:
  - x1=7f0ccccd, x2=7e99999a -> y=7f800000 (overflow).
  - x1=x2=00800000 -> y=00000000 (underflow).
  - x1=7f800000, x2=00000000 -> y=7fc00000.
- Streaming and stall:
  - Four back-to-back operations with stall=1 asserted for 3 cycles mid-stream.
  - Results must emerge in order, none lost or duplicated.
  - y/out_valid must stay constant while stalled.
- Reset mid-operation: assert rst asynchronously (between edges) with 2 operations in flight -> y=0 and out_valid=0 immediately, and no stale result appears after rst deasserts.
